hazard_control_unit: RTL and testbench
======================================

Name: hazard_control_unit

Overview:
- Producer-side partner of the EX-stage operand forwarding logic in the 5-stage pipeline.
- Forwarding resolves RAW hazards by routing results back to EX. This block handles the cases forwarding cannot cover:
  - load-use stall,
  - taken-branch flush,
  - multi-cycle data-memory handshake freeze.
- Drives the write-enable and bubble/flush controls of PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
- Keeps saturating stall/flush performance counters.

Parameters:
REG_ADDR_W, 3, register address width (8 architectural registers, no hardwired-zero register)
CNT_W, 16, width of performance counters
TIMEOUT, 255, MEM_WAIT cycles tolerated before mem_timeout is flagged

Ports:
clk  in  1  pipeline clock, rising edge
rst  in  1  asynchronous active-high reset
id_rs  in  REG_ADDR_W  source register 1 of instruction in ID
id_rt  in  REG_ADDR_W  source register 2 of instruction in ID
id_usesRs  in  1  ID instruction reads id_rs
id_usesRt  in  1  ID instruction reads id_rt
ID_EX_memRead  in  1  instruction in EX is a load
ID_EX_Rt  in  REG_ADDR_W  destination of load in EX
EX_branchTaken  in  1  branch in EX resolved taken
EX_MEM_memRead  in  1  instruction in MEM reads data memory
EX_MEM_memWrite  in  1  instruction in MEM writes data memory
mem_ack  in  1  data memory completes the current access this cycle
mem_req  out  1  data memory request
pcWrite  out  1  PC load enable
IF_ID_write  out  1  IF/ID register enable
IF_ID_flush  out  1  clear IF/ID to NOP
ID_EX_write  out  1  ID/EX register enable
ID_EX_bubble  out  1  load NOP control word into ID/EX
EX_MEM_write  out  1  EX/MEM register enable
MEM_WB_bubble  out  1  load NOP into MEM/WB
mem_timeout  out  1  sticky memory-timeout flag
stallCount  out  CNT_W  cycles with pcWrite=0
flushCount  out  CNT_W  cycles with IF_ID_flush=1

Behaviour:
- State: RUN and MEM_WAIT, registered. All control outputs are combinational from state and inputs.
- Reset values:
  - state=RUN; wait counter=0; mem_timeout=0; stallCount=0; flushCount=0.
  - Default (non-stall) control values: pcWrite, IF_ID_write, ID_EX_write and EX_MEM_write =1; flush and bubble outputs =0; mem_req=0 unless a memory access is present.
- memAccess = EX_MEM_memRead | EX_MEM_memWrite.
- mem_req = memAccess in RUN; mem_req=1 throughout MEM_WAIT.
- freeze:
  - In RUN: freeze = memAccess & ~mem_ack.
  - In MEM_WAIT: freeze = ~mem_ack.
  - While frozen: pcWrite, IF_ID_write, ID_EX_write and EX_MEM_write =0; MEM_WB_bubble=1.
  - Branch flush and load-use detection are suppressed while frozen.
  - A memory that acks in the same cycle as the request causes zero stall cycles.
- Transitions:
  - RUN -> MEM_WAIT when memAccess & ~mem_ack.
  - MEM_WAIT -> RUN on mem_ack. In the ack cycle the pipeline advances normally and branch/load-use are evaluated that cycle.
  - A back-to-back access entering MEM after the advance is evaluated in RUN on the next cycle.
- Timeout:
  - The wait counter increments each MEM_WAIT cycle and clears on leaving MEM_WAIT.
  - When the counter reaches TIMEOUT, mem_timeout sets. It stays set until rst.
  - The freeze continues regardless of mem_timeout.
- Branch flush (not frozen, EX_branchTaken=1):
  - IF_ID_flush=1, ID_EX_bubble=1, pcWrite=1 (PC takes target).
  - Load-use is ignored that cycle, since the ID instruction is squashed.
- Load-use (not frozen, no branch):
  - Hazard = ID_EX_memRead & ((id_usesRs & id_rs==ID_EX_Rt) | (id_usesRt & id_rt==ID_EX_Rt)).
  - On hazard: pcWrite=0, IF_ID_write=0, ID_EX_bubble=1 for exactly one cycle. The bubble then clears ID_EX_memRead.
  - Register 0 is compared like any other register.
- Priority: freeze > branch flush > load-use.
- Counters:
  - stallCount increments on every cycle with pcWrite=0.
  - flushCount increments on every cycle with IF_ID_flush=1.
  - Both saturate at all-ones and never wrap.
- Reset mid-MEM_WAIT: state returns to RUN immediately; the wait counter clears.

Decomposition:
- Package hazard_pkg: state enum {RUN, MEM_WAIT}; REG_ADDR_W default constant.
- One sub-module sat_counter (width CNT_W, inc, async rst), instantiated for stallCount and flushCount.

Test Plan:
- Load-use: ID_EX_memRead=1, ID_EX_Rt=3, id_rs=3, id_usesRs=1, no memAccess -> one cycle of pcWrite=0, IF_ID_write=0, ID_EX_bubble=1; stallCount 0->1. Repeat with id_usesRs=0 -> no stall.
- Branch with concurrent load-use: EX_branchTaken=1 and load-use hazard present -> IF_ID_flush=1, ID_EX_bubble=1, pcWrite=1; stallCount unchanged; flushCount +1.
- Multi-cycle memory: EX_MEM_memRead=1, mem_ack low for 3 cycles then high -> mem_req high 4 cycles; freeze 3 cycles with MEM_WB_bubble=1; advance in the ack cycle; stallCount +3.
- Single-cycle memory: memAccess=1 with mem_ack=1 in the same cycle -> no freeze, state stays RUN.
- Timeout: TIMEOUT=4, mem_ack held low -> mem_timeout rises after the 4th MEM_WAIT cycle and stays high after a later mem_ack; clears only on rst.
- Reset and saturation:
  - Assert rst during MEM_WAIT -> state RUN, all control outputs at default values, counters 0.
  - With CNT_W=2, hold the stall condition for 5 cycles -> stallCount sticks at 3.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and defaults for the pipeline hazard controller.
package hazard_pkg;

  localparam int REG_ADDR_W_DEF = 3;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

endpackage

// File: rtl/hazard_control_unit_sat_counter.sv
// Saturating up-counter used for the stall and flush performance counters.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline hazard controller: memory freeze, taken-branch flush and load-use stall,
// with saturating stall/flush performance counters.
module hazard_control_unit
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEF,
  parameter int CNT_W      = 16,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_usesRs,
  input  logic                  id_usesRt,
  input  logic                  ID_EX_memRead,
  input  logic [REG_ADDR_W-1:0] ID_EX_Rt,
  input  logic                  EX_branchTaken,
  input  logic                  EX_MEM_memRead,
  input  logic                  EX_MEM_memWrite,
  input  logic                  mem_ack,
  output logic                  mem_req,
  output logic                  pcWrite,
  output logic                  IF_ID_write,
  output logic                  IF_ID_flush,
  output logic                  ID_EX_write,
  output logic                  ID_EX_bubble,
  output logic                  EX_MEM_write,
  output logic                  MEM_WB_bubble,
  output logic                  mem_timeout,
  output logic [CNT_W-1:0]      stallCount,
  output logic [CNT_W-1:0]      flushCount
);

  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  state_t            state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              mem_access;
  logic              freeze;
  logic              load_use;

  assign mem_access = EX_MEM_memRead | EX_MEM_memWrite;
  assign freeze     = (state == MEM_WAIT) ? ~mem_ack : (mem_access & ~mem_ack);
  assign load_use   = ID_EX_memRead &
                      ((id_usesRs & (id_rs == ID_EX_Rt)) |
                       (id_usesRt & (id_rt == ID_EX_Rt)));

  always_comb begin
    mem_req       = (state == MEM_WAIT) | mem_access;
    pcWrite       = 1'b1;
    IF_ID_write   = 1'b1;
    IF_ID_flush   = 1'b0;
    ID_EX_write   = 1'b1;
    ID_EX_bubble  = 1'b0;
    EX_MEM_write  = 1'b1;
    MEM_WB_bubble = 1'b0;
    if (freeze) begin
      pcWrite       = 1'b0;
      IF_ID_write   = 1'b0;
      ID_EX_write   = 1'b0;
      EX_MEM_write  = 1'b0;
      MEM_WB_bubble = 1'b1;
    end else if (EX_branchTaken) begin
      // ID instruction is squashed, so any load-use hazard it carries is moot
      IF_ID_flush  = 1'b1;
      ID_EX_bubble = 1'b1;
    end else if (load_use) begin
      pcWrite      = 1'b0;
      IF_ID_write  = 1'b0;
      ID_EX_bubble = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= RUN;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          wait_cnt <= '0;
          if (mem_access && !mem_ack) state <= MEM_WAIT;
        end
        MEM_WAIT: begin
          if (mem_ack) begin
            state    <= RUN;
            wait_cnt <= '0;
          end else begin
            if (wait_cnt != WAIT_MAX) wait_cnt <= wait_cnt + 1'b1;
            // flag is sticky; the freeze keeps going regardless
            if (wait_cnt >= WAIT_LAST) mem_timeout <= 1'b1;
          end
        end
        default: begin
          state    <= RUN;
          wait_cnt <= '0;
        end
      endcase
    end
  end

  sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (~pcWrite),
    .count (stallCount)
  );

  sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (IF_ID_flush),
    .count (flushCount)
  );

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench for hazard_control_unit: scoreboarded control vectors and counter model.
module tb_hazard_control_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] id_rs, id_rt, ID_EX_Rt;
  logic       id_usesRs, id_usesRt, ID_EX_memRead, EX_branchTaken;
  logic       EX_MEM_memRead, EX_MEM_memWrite, mem_ack;

  logic        mem_req, pcWrite, IF_ID_write, IF_ID_flush, ID_EX_write;
  logic        ID_EX_bubble, EX_MEM_write, MEM_WB_bubble, mem_timeout;
  logic [15:0] stallCount, flushCount;

  logic        s_mem_req, s_pcWrite, s_IF_ID_write, s_IF_ID_flush, s_ID_EX_write;
  logic        s_ID_EX_bubble, s_EX_MEM_write, s_MEM_WB_bubble, s_mem_timeout;
  logic [1:0]  s_stallCount, s_flushCount;

  logic [7:0] ctrl, s_ctrl;
  assign ctrl   = {mem_req, pcWrite, IF_ID_write, IF_ID_flush,
                   ID_EX_write, ID_EX_bubble, EX_MEM_write, MEM_WB_bubble};
  assign s_ctrl = {s_mem_req, s_pcWrite, s_IF_ID_write, s_IF_ID_flush,
                   s_ID_EX_write, s_ID_EX_bubble, s_EX_MEM_write, s_MEM_WB_bubble};

  // {mem_req, pcWrite, IF_ID_write, IF_ID_flush, ID_EX_write, ID_EX_bubble, EX_MEM_write, MEM_WB_bubble}
  localparam logic [7:0] NORM   = 8'b0110_1010;
  localparam logic [7:0] NORM_M = 8'b1110_1010;
  localparam logic [7:0] STALL  = 8'b0000_1110;
  localparam logic [7:0] FLUSH  = 8'b0111_1110;
  localparam logic [7:0] FREEZE = 8'b1000_0001;

  always #5 clk = ~clk;

  hazard_control_unit #(.REG_ADDR_W(3), .CNT_W(16), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
    .id_usesRs(id_usesRs), .id_usesRt(id_usesRt),
    .ID_EX_memRead(ID_EX_memRead), .ID_EX_Rt(ID_EX_Rt),
    .EX_branchTaken(EX_branchTaken), .EX_MEM_memRead(EX_MEM_memRead),
    .EX_MEM_memWrite(EX_MEM_memWrite), .mem_ack(mem_ack),
    .mem_req(mem_req), .pcWrite(pcWrite), .IF_ID_write(IF_ID_write),
    .IF_ID_flush(IF_ID_flush), .ID_EX_write(ID_EX_write),
    .ID_EX_bubble(ID_EX_bubble), .EX_MEM_write(EX_MEM_write),
    .MEM_WB_bubble(MEM_WB_bubble), .mem_timeout(mem_timeout),
    .stallCount(stallCount), .flushCount(flushCount)
  );

  hazard_control_unit #(.REG_ADDR_W(3), .CNT_W(2), .TIMEOUT(255)) dut_small (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
    .id_usesRs(id_usesRs), .id_usesRt(id_usesRt),
    .ID_EX_memRead(ID_EX_memRead), .ID_EX_Rt(ID_EX_Rt),
    .EX_branchTaken(EX_branchTaken), .EX_MEM_memRead(EX_MEM_memRead),
    .EX_MEM_memWrite(EX_MEM_memWrite), .mem_ack(mem_ack),
    .mem_req(s_mem_req), .pcWrite(s_pcWrite), .IF_ID_write(s_IF_ID_write),
    .IF_ID_flush(s_IF_ID_flush), .ID_EX_write(s_ID_EX_write),
    .ID_EX_bubble(s_ID_EX_bubble), .EX_MEM_write(s_EX_MEM_write),
    .MEM_WB_bubble(s_MEM_WB_bubble), .mem_timeout(s_mem_timeout),
    .stallCount(s_stallCount), .flushCount(s_flushCount)
  );

  int checks = 0;
  int errors = 0;
  logic [7:0] sb[$];
  int exp_stall, exp_flush, exp_s_stall, exp_s_flush;
  logic exp_to;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_stall"}, 32'(stallCount), 32'(exp_stall));
    chk({tag, "_flush"}, 32'(flushCount), 32'(exp_flush));
    chk({tag, "_s_stall"}, 32'(s_stallCount), 32'(exp_s_stall));
    chk({tag, "_s_flush"}, 32'(s_flushCount), 32'(exp_s_flush));
    chk({tag, "_timeout"}, 32'(mem_timeout), 32'(exp_to));
    chk({tag, "_s_timeout"}, 32'(s_mem_timeout), 32'd0);
  endtask

  // One pipeline cycle: drive, score the control vector, then check counters after the edge.
  task automatic step(input string tag,
                      input logic [2:0] rs, input logic [2:0] rt,
                      input logic urs, input logic urt, input logic exmr,
                      input logic [2:0] exrt, input logic br,
                      input logic mr, input logic mw, input logic ack,
                      input logic [7:0] exp);
    logic [7:0] e;
    id_rs = rs; id_rt = rt; id_usesRs = urs; id_usesRt = urt;
    ID_EX_memRead = exmr; ID_EX_Rt = exrt; EX_branchTaken = br;
    EX_MEM_memRead = mr; EX_MEM_memWrite = mw; mem_ack = ack;
    sb.push_back(exp);
    #2;
    e = sb.pop_front();
    chk({tag, "_ctrl"}, 32'(ctrl), 32'(e));
    chk({tag, "_s_ctrl"}, 32'(s_ctrl), 32'(e));
    if (!e[6]) begin
      if (exp_stall < 65535) exp_stall++;
      if (exp_s_stall < 3) exp_s_stall++;
    end
    if (e[4]) begin
      if (exp_flush < 65535) exp_flush++;
      if (exp_s_flush < 3) exp_s_flush++;
    end
    @(posedge clk);
    #1;
    check_state(tag);
  endtask

  task automatic clear_model();
    exp_stall = 0; exp_flush = 0; exp_s_stall = 0; exp_s_flush = 0; exp_to = 1'b0;
  endtask

  initial begin
    clear_model();
    rst = 1'b1;
    id_rs = '0; id_rt = '0; id_usesRs = 0; id_usesRt = 0;
    ID_EX_memRead = 0; ID_EX_Rt = '0; EX_branchTaken = 0;
    EX_MEM_memRead = 0; EX_MEM_memWrite = 0; mem_ack = 0;
    #1;
    chk("reset_ctrl", 32'(ctrl), 32'(NORM));
    check_state("reset");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // load-use via rs, bubble clears load, no hazard when rs unused, via rt, register 0
    step("lu_rs",     3'd3, 3'd0, 1, 0, 1, 3'd3, 0, 0, 0, 0, STALL);
    step("lu_clear",  3'd3, 3'd0, 1, 0, 0, 3'd3, 0, 0, 0, 0, NORM);
    step("lu_nouse",  3'd3, 3'd0, 0, 0, 1, 3'd3, 0, 0, 0, 0, NORM);
    step("lu_rt",     3'd1, 3'd5, 0, 1, 1, 3'd5, 0, 0, 0, 0, STALL);
    step("lu_nomatch",3'd1, 3'd5, 1, 1, 1, 3'd6, 0, 0, 0, 0, NORM);
    step("lu_r0",     3'd0, 3'd7, 1, 0, 1, 3'd0, 0, 0, 0, 0, STALL);

    // taken branch wins over load-use
    step("br_lu",     3'd3, 3'd0, 1, 0, 1, 3'd3, 1, 0, 0, 0, FLUSH);

    // three-cycle memory read; branch during freeze is suppressed
    step("mem_w0",    3'd0, 3'd0, 0, 0, 0, 3'd0, 0, 1, 0, 0, FREEZE);
    step("mem_w1_br", 3'd0, 3'd0, 0, 0, 0, 3'd0, 1, 1, 0, 0, FREEZE);
    step("mem_w2",    3'd0, 3'd0, 0, 0, 0, 3'd0, 0, 1, 0, 0, FREEZE);
    step("mem_ack",   3'd0, 3'd0, 0, 0, 0, 3'd0, 0, 1, 0, 1, NORM_M);

    // single-cycle write, then RUN must remain unfrozen
    step("mem_1cyc",  3'd0, 3'd0, 0, 0, 0, 3'd0, 0, 0, 1, 1, NORM_M);
    step("post_1cyc", 3'd0, 3'd0, 0, 0, 0, 3'd0, 0, 0, 0, 0, NORM);

    // branch evaluated in the MEM_WAIT ack cycle
    step("ackbr_w0",  3'd0, 3'd0, 0, 0, 0, 3'd0, 0, 1, 0, 0, FREEZE);
    step("ackbr_ack", 3'd0, 3'd0, 0, 0, 0, 3'd0, 1, 1, 0, 1, 8'b1111_1110);

    // timeout after the 4th MEM_WAIT cycle, sticky past ack
    step("to_run",    3'd0, 3'd0, 0, 0, 0, 3'd0, 0, 1, 0, 0, FREEZE);
    step("to_w1",     3'd0, 3'd0, 0, 0, 0, 3'd0, 0, 1, 0, 0, FREEZE);
    step("to_w2",     3'd0, 3'd0, 0, 0, 0, 3'd0, 0, 1, 0, 0, FREEZE);
    step("to_w3",     3'd0, 3'd0, 0, 0, 0, 3'd0, 0, 1, 0, 0, FREEZE);
    exp_to = 1'b1;
    step("to_w4",     3'd0, 3'd0, 0, 0, 0, 3'd0, 0, 1, 0, 0, FREEZE);
    step("to_ack",    3'd0, 3'd0, 0, 0, 0, 3'd0, 0, 1, 0, 1, NORM_M);
    step("to_after",  3'd0, 3'd0, 0, 0, 0, 3'd0, 0, 0, 0, 0, NORM);

    // reset while in MEM_WAIT
    step("rst_w0",    3'd0, 3'd0, 0, 0, 0, 3'd0, 0, 1, 0, 0, FREEZE);
    step("rst_w1",    3'd0, 3'd0, 0, 0, 0, 3'd0, 0, 1, 0, 0, FREEZE);
    EX_MEM_memRead = 0;
    rst = 1'b1;
    clear_model();
    #1;
    chk("rst_mid_ctrl", 32'(ctrl), 32'(NORM));
    check_state("rst_mid");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    step("rst_run",   3'd0, 3'd0, 0, 0, 0, 3'd0, 0, 0, 0, 0, NORM);

    // hold a load-use stall for five cycles; the 2-bit counter sticks at 3
    for (int i = 0; i < 5; i++)
      step("sat", 3'd2, 3'd0, 1, 0, 1, 3'd2, 0, 0, 0, 0, STALL);
    chk("sat_s_final", 32'(s_stallCount), 32'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
